hazard_stall_ctrl: RTL

- Pipeline sequencing controller for the 5-stage MIPS core. Each cycle it decides whether the ID/EX register loads the decoded instruction or is cleared to a bubble.
- Decides stall vs. advance from register-use/produce timing (Tuse/Tnew) of the D, E and M stages.
- Owns a multi-cycle mult/div busy sequencer (FSM plus down-counter) and a saturating stall-cycle counter.
- Drives the PC enable, the IF/ID enable and the ID/EX clr input.

---
 rtl/hazard_stall_ctrl_pkg.sv | 16 +
 rtl/hazard_stall_ctrl_md_seq.sv | 58 +++++
 rtl/hazard_stall_ctrl.sv | 71 +++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing logic of the 5-stage MIPS core.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE     = 2'd0,
        MD_BUSY_MUL = 2'd1,
        MD_BUSY_DIV = 2'd2
    } md_state_e;

    // Tuse value meaning the operand is never read by the D instruction.
    localparam logic [1:0] TUSE_NEVER = 2'd3;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/hazard_stall_ctrl_md_seq.sv
// Mult/div busy sequencer: tracks how long the MD unit stays busy after a start.
module md_busy_seq
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    md_state_e       state, state_next;
    logic [CW-1:0]   cnt, cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A start while busy is deliberately ignored; the busy window never restarts.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            MD_IDLE: begin
                if (md_start) begin
                    cnt_next   = md_div ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
                    state_next = md_div ? MD_BUSY_DIV : MD_BUSY_MUL;
                end
            end
            MD_BUSY_MUL, MD_BUSY_DIV: begin
                if (cnt == '0) begin
                    state_next = MD_IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = MD_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign md_busy = (state != MD_IDLE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/advance decision for the D stage from Tuse/Tnew timing and MD unit occupancy.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [1:0]       tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic             md_use_D,
    input  logic [4:0]       wa_E,
    input  logic [1:0]       tnew_E,
    input  logic             regwr_E,
    input  logic [4:0]       wa_M,
    input  logic [1:0]       tnew_M,
    input  logic             regwr_M,
    input  logic             md_start_E,
    input  logic             md_div_E,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             clr_E,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic uses_rs, uses_rt;
    logic hz_rs, hz_rt, hz_md, stall;

    md_busy_seq #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_seq (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start_E),
        .md_div   (md_div_E),
        .md_busy  (md_busy)
    );

    // $zero is hardwired, so a match on register 0 is never a real dependency.
    assign uses_rs = (rs_D != 5'd0) && (tuse_rs_D != TUSE_NEVER);
    assign uses_rt = (rt_D != 5'd0) && (tuse_rt_D != TUSE_NEVER);

    assign hz_rs = uses_rs &&
                   ((regwr_E && (wa_E == rs_D) && (tuse_rs_D < tnew_E)) ||
                    (regwr_M && (wa_M == rs_D) && (tuse_rs_D < tnew_M)));
    assign hz_rt = uses_rt &&
                   ((regwr_E && (wa_E == rt_D) && (tuse_rt_D < tnew_E)) ||
                    (regwr_M && (wa_M == rt_D) && (tuse_rt_D < tnew_M)));
    assign hz_md = md_use_D && (md_busy || md_start_E);

    // Holding reset forces the pipeline to advance regardless of hazard inputs.
    assign stall   = !reset && (hz_rs || hz_rt || hz_md);
    assign pc_en   = !stall;
    assign ifid_en = !stall;
    assign clr_E   = stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
